stream_compare_seq: RTL and testbench

STREAM_COMPARE_SEQ -- requirements
Module: stream_compare_seq

---
 rtl/stream_compare_seq.sv | 202 ++++++++++++++++++++
 tb/tb_stream_compare_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_compare_seq.sv
// Run sequencer for a stream comparator: clears the comparator, lets it run
// until a stop condition fires, latches its counts and reports a sticky status.
module stream_compare_seq #(
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned CLEAR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] target_words,
    input  logic [CNT_WIDTH-1:0] err_limit,
    input  logic [CNT_WIDTH-1:0] timeout_cycles,
    input  logic [CNT_WIDTH-1:0] word_count,
    input  logic [CNT_WIDTH-1:0] err_count,
    output logic                 cmp_reset,
    output logic                 cmp_latch,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           status,
    output logic [CNT_WIDTH-1:0] result_words,
    output logic [CNT_WIDTH-1:0] result_errs,
    output logic [CNT_WIDTH-1:0] run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_LATCH = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ST_NONE    = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_ABORT   = 3'd4
    } status_e;

    // Why RUN ended; decides the status reported at DONE.
    typedef enum logic [1:0] {
        C_TARGET  = 2'd0,
        C_ERR     = 2'd1,
        C_TIMEOUT = 2'd2,
        C_ABORT   = 2'd3
    } cause_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]           CLR_LAST = 4'(CLEAR_CYCLES - 1);

    state_e                state_q, state_d;
    cause_e                cause_q, cause_d;
    status_e               status_q, status_d;
    logic [3:0]            clr_cnt_q, clr_cnt_d;
    logic [CNT_WIDTH-1:0]  target_q, target_d;
    logic [CNT_WIDTH-1:0]  err_limit_q, err_limit_d;
    logic [CNT_WIDTH-1:0]  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  run_cycles_q, run_cycles_d;
    logic [CNT_WIDTH-1:0]  result_words_q, result_words_d;
    logic [CNT_WIDTH-1:0]  result_errs_q, result_errs_d;
    logic                  cmp_reset_q, cmp_reset_d;
    logic                  cmp_latch_q, cmp_latch_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  hit_timeout;
    logic                  hit_err;
    logic                  hit_target;

    // Stop conditions seen during RUN; the timeout fires on the cycle that
    // brings run_cycles up to the programmed limit.
    always_comb begin
        hit_timeout = (timeout_q != '0) && ((run_cycles_q + CNT_ONE) == timeout_q);
        hit_err     = (err_limit_q != '0) && (err_count >= err_limit_q);
        hit_target  = (word_count >= target_q);
    end

    // Next-state, captured values and registered Moore outputs.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d        = state_q;
        cause_d        = cause_q;
        status_d       = status_q;
        clr_cnt_d      = clr_cnt_q;
        target_d       = target_q;
        err_limit_d    = err_limit_q;
        timeout_d      = timeout_q;
        run_cycles_d   = run_cycles_q;
        result_words_d = result_words_q;
        result_errs_d  = result_errs_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d      = S_CLEAR;
                    target_d     = target_words;
                    err_limit_d  = err_limit;
                    timeout_d    = timeout_cycles;
                    clr_cnt_d    = '0;
                    run_cycles_d = '0;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    // Nothing was compared yet, so the reported counts are zero.
                    state_d        = S_DONE;
                    status_d       = ST_ABORT;
                    result_words_d = '0;
                    result_errs_d  = '0;
                end else if (clr_cnt_q == CLR_LAST) begin
                    state_d = S_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            S_RUN: begin
                run_cycles_d = (run_cycles_q == CNT_MAX) ? CNT_MAX : run_cycles_q + CNT_ONE;
                if (abort || hit_timeout || hit_err || hit_target) begin
                    state_d = S_LATCH;
                    if (abort)            cause_d = C_ABORT;
                    else if (hit_timeout) cause_d = C_TIMEOUT;
                    else if (hit_err)     cause_d = C_ERR;
                    else                  cause_d = C_TARGET;
                end
            end
            S_LATCH: begin
                // Counts and status land together so they change only at DONE.
                state_d        = S_DONE;
                result_words_d = word_count;
                result_errs_d  = err_count;
                case (cause_q)
                    C_ABORT:   status_d = ST_ABORT;
                    C_TIMEOUT: status_d = ST_TIMEOUT;
                    C_ERR:     status_d = ST_FAIL;
                    default:   status_d = (err_count != '0) ? ST_FAIL : ST_PASS;
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmp_reset_d = (state_d == S_CLEAR);
        cmp_latch_d = (state_d == S_LATCH);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!aresetn) begin
            state_q        <= S_IDLE;
            cause_q        <= C_TARGET;
            status_q       <= ST_NONE;
            clr_cnt_q      <= '0;
            target_q       <= '0;
            err_limit_q    <= '0;
            timeout_q      <= '0;
            run_cycles_q   <= '0;
            result_words_q <= '0;
            result_errs_q  <= '0;
            cmp_reset_q    <= 1'b0;
            cmp_latch_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cause_q        <= cause_d;
            status_q       <= status_d;
            clr_cnt_q      <= clr_cnt_d;
            target_q       <= target_d;
            err_limit_q    <= err_limit_d;
            timeout_q      <= timeout_d;
            run_cycles_q   <= run_cycles_d;
            result_words_q <= result_words_d;
            result_errs_q  <= result_errs_d;
            cmp_reset_q    <= cmp_reset_d;
            cmp_latch_q    <= cmp_latch_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign cmp_reset    = cmp_reset_q;
    assign cmp_latch    = cmp_latch_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign status       = status_q;
    assign result_words = result_words_q;
    assign result_errs  = result_errs_q;
    assign run_cycles   = run_cycles_q;

endmodule

// File: tb/tb_stream_compare_seq.sv
// Directed bench for stream_compare_seq with a small comparator model that
// counts words from a finite source and errors inside a chosen word window.
module tb_stream_compare_seq;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          start;
    logic          abort;
    logic [CW-1:0] target_words;
    logic [CW-1:0] err_limit;
    logic [CW-1:0] timeout_cycles;
    logic [CW-1:0] word_count;
    logic [CW-1:0] err_count;
    logic          cmp_reset;
    logic          cmp_latch;
    logic          busy;
    logic          done;
    logic [2:0]    status;
    logic [CW-1:0] result_words;
    logic [CW-1:0] result_errs;
    logic [CW-1:0] run_cycles;

    // Comparator model controls
    logic [CW-1:0] src_len;
    logic          ramp_en;
    logic [CW-1:0] err_lo;
    logic [CW-1:0] err_hi;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int c0      = 0;
    int done_seen  = 0;
    int crst_cnt   = 0;
    int latch_cnt  = 0;

    stream_compare_seq #(.CNT_WIDTH(CW), .CLEAR_CYCLES(2)) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .start          (start),
        .abort          (abort),
        .target_words   (target_words),
        .err_limit      (err_limit),
        .timeout_cycles (timeout_cycles),
        .word_count     (word_count),
        .err_count      (err_count),
        .cmp_reset      (cmp_reset),
        .cmp_latch      (cmp_latch),
        .busy           (busy),
        .done           (done),
        .status         (status),
        .result_words   (result_words),
        .result_errs    (result_errs),
        .run_cycles     (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge, then the comparator
    // model advances its counts for the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1)      done_seen++;
        if (cmp_latch === 1'b1) latch_cnt++;
        if (cmp_reset === 1'b1) begin
            crst_cnt++;
            word_count = '0;
            err_count  = '0;
        end else if (ramp_en && word_count < src_len) begin
            word_count = word_count + 1;
            if (word_count >= err_lo && word_count <= err_hi) err_count = err_count + 1;
        end
    endtask

    task automatic start_run(input logic [CW-1:0] tgt, input logic [CW-1:0] elim,
                             input logic [CW-1:0] tmo, input logic [CW-1:0] len,
                             input logic ramp, input logic [CW-1:0] lo, input logic [CW-1:0] hi);
        target_words   = tgt;
        err_limit      = elim;
        timeout_cycles = tmo;
        src_len        = len;
        ramp_en        = ramp;
        err_lo         = lo;
        err_hi         = hi;
        done_seen      = 0;
        crst_cnt       = 0;
        latch_cnt      = 0;
        start          = 1'b1;
        tick();
        start          = 1'b0;
        c0             = cyc;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        aresetn = 1'b0; start = 1'b0; abort = 1'b0;
        target_words = '0; err_limit = '0; timeout_cycles = '0;
        word_count = '0; err_count = '0;
        src_len = '0; ramp_en = 1'b0; err_lo = 1; err_hi = 0;

        // Reset state
        idle_ticks(3);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_cmp_reset", {63'd0, cmp_reset}, 64'd0);
        check("rst_status", {61'd0, status}, 64'd0);
        check("rst_result_words", {32'd0, result_words}, 64'd0);
        aresetn = 1'b1;
        tick();

        // Normal pass: 100 words, no errors
        start_run(100, 0, 0, 100, 1'b1, 1, 0);
        check("pass_busy", {63'd0, busy}, 64'd1);
        wait_done("pass_done", 300);
        check("pass_latency", 64'(cyc - c0), 64'd103);
        check("pass_status", {61'd0, status}, 64'd1);
        check("pass_words", {32'd0, result_words}, 64'd100);
        check("pass_errs", {32'd0, result_errs}, 64'd0);
        check("pass_run_cycles", {32'd0, run_cycles}, 64'd100);
        idle_ticks(3);
        check("pass_cmp_reset_cycles", 64'(crst_cnt), 64'd2);
        check("pass_latch_pulses", 64'(latch_cnt), 64'd1);
        check("pass_done_pulses", 64'(done_seen), 64'd1);
        check("pass_idle", {63'd0, busy}, 64'd0);

        // Error-limit stop: errors on words 36..40, limit 5
        start_run(1000, 5, 0, 1000, 1'b1, 36, 40);
        wait_done("err_done", 300);
        check("err_status", {61'd0, status}, 64'd2);
        check("err_errs", {32'd0, result_errs}, 64'd5);
        check("err_words", {32'd0, result_words}, 64'd41);
        check("err_run_cycles", {32'd0, run_cycles}, 64'd40);
        idle_ticks(3);

        // Abort during CLEAR; previous status must hold until this DONE
        start_run(100, 0, 0, 100, 1'b1, 1, 0);
        check("hold_status", {61'd0, status}, 64'd2);
        check("hold_errs", {32'd0, result_errs}, 64'd5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("clr_abort_done", {63'd0, done}, 64'd1);
        check("clr_abort_cmp_reset", {63'd0, cmp_reset}, 64'd0);
        check("clr_abort_status", {61'd0, status}, 64'd4);
        check("clr_abort_words", {32'd0, result_words}, 64'd0);
        check("clr_abort_errs", {32'd0, result_errs}, 64'd0);
        idle_ticks(3);
        check("clr_abort_reset_cycles", 64'(crst_cnt), 64'd1);
        check("clr_abort_done_pulses", 64'(done_seen), 64'd1);

        // Timeout with a frozen word count
        start_run(1000, 0, 50, 1000, 1'b0, 1, 0);
        wait_done("tmo_done", 300);
        check("tmo_status", {61'd0, status}, 64'd3);
        check("tmo_run_cycles", {32'd0, run_cycles}, 64'd50);
        check("tmo_words", {32'd0, result_words}, 64'd0);
        idle_ticks(3);

        // Abort on the same cycle the target is reached
        start_run(10, 0, 0, 10, 1'b1, 1, 0);
        begin
            int n = 0;
            while (word_count != 10 && n < 100) begin
                tick();
                n++;
            end
        end
        check("abt_reached", {32'd0, word_count}, 64'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("abt_done", 20);
        check("abt_status", {61'd0, status}, 64'd4);
        check("abt_words", {32'd0, result_words}, 64'd10);
        idle_ticks(3);
        check("abt_done_pulses", 64'(done_seen), 64'd1);

        // Reset mid-RUN, start held through reset release
        start_run(100, 0, 0, 100, 1'b1, 1, 0);
        idle_ticks(20);
        done_seen = 0;
        aresetn = 1'b0;
        tick();
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_status", {61'd0, status}, 64'd0);
        check("mid_rst_words", {32'd0, result_words}, 64'd0);
        target_words = 20; src_len = 20;
        start = 1'b1;
        tick();
        aresetn = 1'b1;
        tick();
        start = 1'b0;
        check("rel_accept", {63'd0, cmp_reset}, 64'd1);
        wait_done("rel_done", 100);
        check("rel_status", {61'd0, status}, 64'd1);
        check("rel_words", {32'd0, result_words}, 64'd20);
        check("rel_run_cycles", {32'd0, run_cycles}, 64'd20);
        idle_ticks(3);
        check("rel_done_pulses", 64'(done_seen), 64'd1);

        // target=0 with start pulses while busy
        start_run(0, 0, 0, 0, 1'b1, 1, 0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done("zero_done", 20);
        check("zero_status", {61'd0, status}, 64'd1);
        check("zero_words", {32'd0, result_words}, 64'd0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("zero_start_in_done", {63'd0, busy}, 64'd0);
        idle_ticks(3);
        check("zero_done_pulses", 64'(done_seen), 64'd1);

        // start with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {63'd0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
